// File: rtl/turf_mode1_extract_if.sv
// Received TURF command stream plus the mode-1 byte AXI4-stream, bundled for turf_mode1_extract.
interface turf_mode1_extract_if;
    logic        command_locked_i;
    logic [31:0] command_i;
    logic        command_valid_i;
    logic [7:0]  mode1_tdata;
    logic        mode1_tvalid;
    logic        mode1_tready;
    logic [1:0]  mode1_tuser;

    modport master (
        output command_locked_i, command_i, command_valid_i, mode1_tready,
        input  mode1_tdata, mode1_tvalid, mode1_tuser
    );

    modport slave (
        input  command_locked_i, command_i, command_valid_i, mode1_tready,
        output mode1_tdata, mode1_tvalid, mode1_tuser
    );
endinterface

// File: rtl/turf_mode1_extract.sv
// Extracts mode-1 payload bytes from TURF command words into a FWFT byte FIFO (AXI4-stream out).
// Optional macro TURF_MODE1_DROP_COUNT_EN enables the saturating dropped-command counter.
module turf_mode1_extract #(
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [1:0]  CMD_TYPE_MODE1 = 2'b01
) (
    input  logic                          sysclk_i,
    input  logic                          sysclk_rst_i,
    turf_mode1_extract_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    output logic [15:0]                   dropped_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [9:0]    mem [FIFO_DEPTH];

    logic          stg_valid;
    logic [1:0]    stg_idx, stg_n;
    logic [23:0]   stg_data;
    logic          stg_sof, stg_eof;

    logic          flush, candidate, accept, drop;
    logic [1:0]    cmd_n;
    logic [AW:0]   free;
    logic          push, pop, stg_last;
    logic [7:0]    push_byte;
    logic [9:0]    push_word, head;
    logic          unused_cmd_bits;

    assign unused_cmd_bits = ^bus.command_i[29:28];

    assign flush     = !bus.command_locked_i;
    assign cmd_n     = bus.command_i[25:24];
    assign candidate = bus.command_valid_i && bus.command_locked_i &&
                       (bus.command_i[31:30] == CMD_TYPE_MODE1) && (cmd_n != 2'd0);
    assign free      = (AW+1)'(FIFO_DEPTH) - count;
    assign accept    = candidate && !stg_valid && (free >= (AW+1)'(cmd_n));
    assign drop      = candidate && !accept;

    assign push      = stg_valid;
    assign pop       = (count != '0) && bus.mode1_tready;
    assign stg_last  = (stg_idx == stg_n - 2'd1);

    always_comb begin
        push_byte = stg_data[7:0];
        case (stg_idx)
            2'd1:    push_byte = stg_data[15:8];
            2'd2:    push_byte = stg_data[23:16];
            default: push_byte = stg_data[7:0];
        endcase
    end

    // SOF belongs to byte0 only, EOF to the last byte of the command only
    assign push_word = {stg_eof && stg_last, stg_sof && (stg_idx == 2'd0), push_byte};

    assign head             = mem[rd_ptr];
    assign bus.mode1_tvalid = (count != '0);
    assign bus.mode1_tdata  = bus.mode1_tvalid ? head[7:0] : '0;
    assign bus.mode1_tuser  = bus.mode1_tvalid ? head[9:8] : '0;
    assign fifo_count_o     = count;

    always_ff @(posedge sysclk_i) begin
        if (push && !flush)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
        if (sysclk_rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stg_valid  <= 1'b0;
            stg_idx    <= '0;
            stg_n      <= '0;
            stg_data   <= '0;
            stg_sof    <= 1'b0;
            stg_eof    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= drop;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                stg_valid <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (accept) begin
                    stg_valid <= 1'b1;
                    stg_idx   <= '0;
                    stg_n     <= cmd_n;
                    stg_data  <= bus.command_i[23:0];
                    stg_sof   <= bus.command_i[26];
                    stg_eof   <= bus.command_i[27];
                end else if (push) begin
                    if (stg_last) stg_valid <= 1'b0;
                    else          stg_idx   <= stg_idx + 2'd1;
                end
            end
        end
    end

`ifdef TURF_MODE1_DROP_COUNT_EN
    logic [15:0] drop_cnt;
    always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
        if (sysclk_rst_i)
            drop_cnt <= '0;
        else if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + 16'd1;
    end
    assign dropped_count_o = drop_cnt;
`else
    assign dropped_count_o = '0;
`endif
endmodule

// File: doc/turf_mode1_extract.md
Name: turf_mode1_extract

Overview:
Sits directly upstream of the TURFIO command splice, in the sysclk domain.
- Consumes the received TURF command stream (command word, valid, locked) produced by the TURF interface.
- Pulls mode-1 payload bytes out of mode-1 command words and buffers them in a small FIFO.
- Presents the bytes as the 8-bit AXI4-stream mode1_ (tdata/tvalid/tready plus 2-bit tuser) that the splice consumes.

Parameters:
FIFO_DEPTH, 16, byte FIFO depth; power of 2, >= 4
CMD_TYPE_MODE1, 2'b01, value of command_i[31:30] identifying a mode-1 command

Ports:
sysclk_i  in  1  system clock; everything is synchronous to it
sysclk_rst_i  in  1  asynchronous, active-high reset
command_locked_i  in  1  TURF command link locked
command_i  in  32  received command word
command_valid_i  in  1  command_i valid strobe; upstream guarantees at most one strobe per 4 cycles
mode1_tdata  out  8  payload byte
mode1_tvalid  out  1  byte available
mode1_tready  in  1  consumer accepts byte
mode1_tuser  out  2  [0]=start-of-frame, [1]=end-of-frame for this byte
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow_o  out  1  one-cycle pulse when a mode-1 command is dropped
dropped_count_o  out  16  dropped-command counter (see Optional Feature)

Behaviour:
Command word format:
- [31:30] type
- [27] EOF flag
- [26] SOF flag
- [25:24] byte count N
- [23:16] byte2, [15:8] byte1, [7:0] byte0

Candidate:
- command_valid_i && command_locked_i && type==CMD_TYPE_MODE1 && N!=0.
- N==0 or any other type: ignored; not a drop, no state change.

Accept vs drop:
- A candidate is accepted only if the staging register is empty and FIFO free entries >= N.
- Otherwise the whole command is dropped: no partial write, overflow_o pulses the next cycle.

Staging:
- An accepted command latches N bytes plus flags into a 3-byte staging register.
- One byte per cycle moves into the FIFO in order byte0, byte1, byte2, starting the cycle after acceptance.
- SOF attaches to byte0 only; EOF attaches to byte N-1 only.
- Example: N=1 with SOF=EOF=1 gives tuser=2'b11 on that byte.
- The staging register is empty again the cycle after its last byte is written.

FIFO:
- First-word-fall-through.
- mode1_tvalid = occupancy != 0; mode1_tdata/tuser show the head entry combinationally from the memory.
- A pop occurs on mode1_tvalid && mode1_tready.
- Write pointer, read pointer and occupancy wrap modulo FIFO_DEPTH / count 0..FIFO_DEPTH.
- Simultaneous push and pop: occupancy unchanged.
- A push is never presented when full (guaranteed by the space check).
- A pop while empty is ignored.
- fifo_count_o is the registered occupancy.

Latency:
- command_valid_i at cycle t gives byte0 at mode1_tvalid in cycle t+2 (staging at t+1, FIFO write at t+1→t+2) if the FIFO was empty.

Lock loss:
- Any cycle with command_locked_i==0 flushes the staging register and the FIFO synchronously.
- mode1_tvalid is 0 from the next cycle.
- A command_valid_i in that same cycle is ignored.
- Flushing does not count as a drop.

Reset (async assert):
- mode1_tvalid=0, mode1_tdata=0, mode1_tuser=0.
- Pointers and occupancy 0, fifo_count_o=0, overflow_o=0, dropped_count_o=0, staging empty.
- Reset mid-stream discards all buffered bytes.

Optional Feature:
Macro: TURF_MODE1_DROP_COUNT_EN.
- Defined: dropped_count_o increments by 1 on each overflow_o pulse and saturates at 16'hFFFF. It clears only on reset.
- Undefined: dropped_count_o is tied to 16'h0000 and no counter logic exists. overflow_o behaves identically in both builds.

Test Plan:
- Locked, idle FIFO, single command 32'h4702_BBAA at t (N=3, SOF=1, EOF=0) → bytes AA(tuser 01), BB(00), 02(00) at t+2..t+4 with tready=1; fifo_count_o peaks at 1.
- N=1 command with SOF=EOF=1 and data 0x5C → one byte 0x5C with tuser=2'b11; type 2'b10 command and N=0 command produce no output and no overflow.
- tready=0, 6 N=3 commands spaced 4 cycles apart, FIFO_DEPTH=16 → first 5 accepted (count 15), 6th dropped: overflow_o pulses once, count stays 15, dropped_count_o=1 (macro on) / 0 (macro off).
- FIFO holding 10 bytes, deassert command_locked_i for 1 cycle → tvalid=0 and fifo_count_o=0 next cycle; overflow_o stays 0.
- Continuous tready with push and pop in the same cycle over 40 commands → count never exceeds 3, the byte order matches the input, and the pointers wrap correctly past 16.
- Assert sysclk_rst_i mid-stream asynchronously → outputs go to reset values immediately; the first command after release yields byte0 at +2 cycles.
